mem_cmd_queue: RTL

- Command buffer and issuer directly upstream of the memory block.
- Accepts write/read commands from a producer over valid/ready and holds them in an in-order FIFO.
- Issues commands one at a time on the memory's wr_rd/addr/wdata/valid/ready port and returns read data on a response port.
- Decouples stimulus/producer timing from memory backpressure.

---
 rtl/mem_cmd_queue_if.sv | 45 ++++
 rtl/mem_cmd_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_queue_if.sv
// Bundle of all non-clock signals of the memory command queue: producer
// command input, memory issue port, read response port and status.
interface mem_cmd_queue_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int QDEPTH     = 4
);
  localparam int CW = $clog2(QDEPTH) + 1;

  // producer side
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_wr_rd;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [WIDTH-1:0]      in_wdata;

  // memory side
  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_wr_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;

  // read response and status
  logic                  rsp_valid;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [WIDTH-1:0]      rsp_data;
  logic [CW-1:0]         count;
  logic                  busy;

  // queue view
  modport slave (
    input  in_valid, in_wr_rd, in_addr, in_wdata, mem_ready, mem_rdata,
    output in_ready, mem_valid, mem_wr_rd, mem_addr, mem_wdata,
    output rsp_valid, rsp_addr, rsp_data, count, busy
  );

  // producer / memory view
  modport master (
    output in_valid, in_wr_rd, in_addr, in_wdata, mem_ready, mem_rdata,
    input  in_ready, mem_valid, mem_wr_rd, mem_addr, mem_wdata,
    input  rsp_valid, rsp_addr, rsp_data, count, busy
  );
endinterface

// File: rtl/mem_cmd_queue.sv
// In-order command FIFO plus a three-state issuer in front of a single-port
// memory. Commands are popped one at a time, held stable on the memory port
// until accepted, and read data is returned as a one-cycle response pulse.
module mem_cmd_queue #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int QDEPTH     = 4
) (
  input  logic            clk,
  input  logic            res,
  mem_cmd_queue_if.slave  bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_WIDTH + WIDTH;

  // Reject FIFO sizes the pointer wrap cannot handle, and memories that the
  // address bus cannot reach.
  if (((1 << PW) != QDEPTH) || (QDEPTH < 2) || (DEPTH > (1 << ADDR_WIDTH))) begin : g_param_check
    $error("mem_cmd_queue: QDEPTH must be a power of 2 >= 2 and DEPTH must fit ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  // FIFO storage, entry layout {wr_rd, addr, wdata}
  logic [EW-1:0]         fifo_q [QDEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;

  // issuer state and registered outputs
  state_t                state_q;
  logic                  mem_valid_q;
  logic                  mem_wr_rd_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0]      mem_wdata_q;
  logic                  rsp_valid_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic [WIDTH-1:0]      rsp_data_q;

  logic                  in_ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic [EW-1:0]         entry_in_s;
  logic [EW-1:0]         head_s;

  // Ready only looks at the registered fill level, never at in_valid.
  assign in_ready_s = (count_q < CW'(QDEPTH));
  assign push_s     = bus.in_valid && in_ready_s;
  // The issuer only takes a new command when it is idle.
  assign pop_s      = (state_q == ST_IDLE) && (count_q != '0);
  assign entry_in_s = {bus.in_wr_rd, bus.in_addr, bus.in_wdata};
  assign head_s     = fifo_q[rptr_q];

  // Next pointer and fill level; pointers wrap naturally at the power-of-2 size.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointer registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_q[wptr_q] <= entry_in_s;
      end else begin
        fifo_q[wptr_q] <= fifo_q[wptr_q];
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Issue FSM: pop into the memory port, hold until accepted, collect read data.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            {mem_wr_rd_q, mem_addr_q, mem_wdata_q} <= head_s;
            mem_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end else begin
            mem_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // mem_* stay untouched here so the memory sees a stable command.
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= mem_wr_rd_q ? ST_IDLE : ST_RD_WAIT;
          end else begin
            mem_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_RD_WAIT: begin
          // Memory presents read data the cycle after the read handshake.
          rsp_data_q  <= bus.mem_rdata;
          rsp_addr_q  <= mem_addr_q;
          rsp_valid_q <= 1'b1;
          mem_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          mem_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_wr_rd = mem_wr_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.count     = count_q;
  assign bus.busy      = (count_q != '0) || (state_q != ST_IDLE);

endmodule
